// File: rtl/core_sequencer_if.sv
// core_sequencer_if
// Instruction- and data-memory handshake bundle for core_sequencer.
//   imem_req   : fetch request, level, held until imem_ack
//   imem_addr  : fetch address (current pc)
//   imem_ack   : fetch data valid this cycle
//   imem_rdata : fetched instruction word
//   dmem_req   : data access request, level, held until dmem_ack
//   dmem_we    : store qualifier, valid while dmem_req=1
//   dmem_ack   : data access complete
// master = sequencer side, slave = memory side.
interface core_sequencer_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer
// Multi-cycle control sequencer for an RV32I core. Owns the pc, fetches over
// a req/ack instruction port, stretches execution across variable-latency
// memories, gates writeback, counts retired instructions and parks on
// halt or trap.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   prog         : program mode, parks the core in PROG
//   mem          : instruction/data memory handshakes (master side)
//   instr        : latched current instruction
//   is_mem/is_store/is_halt : decoder flags for the current instruction
//   pc_next      : next pc from the datapath
//   pc           : current program counter
//   ex_stage     : one-cycle execute strobe
//   wb_stage     : one-cycle writeback strobe (regfile write qualifier)
//   state        : current state encoding
//   instret      : retired instruction count (wraps)
//   halted, trap : in HALT / in TRAP
//   trap_cause   : 0 none, 1 misaligned pc_next, 2 imem timeout, 3 dmem timeout
// Every output is a register or a decode of the state register.
module core_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              CNT_W    = 64,
  parameter int              TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prog,
  core_sequencer_if.master        mem,
  output logic [31:0]             instr,
  input  logic                    is_mem,
  input  logic                    is_store,
  input  logic                    is_halt,
  input  logic [XLEN-1:0]         pc_next,
  output logic [XLEN-1:0]         pc,
  output logic                    ex_stage,
  output logic                    wb_stage,
  output logic [2:0]              state,
  output logic [CNT_W-1:0]        instret,
  output logic                    halted,
  output logic                    trap,
  output logic [1:0]              trap_cause
);

  typedef enum logic [2:0] {
    S_PROG  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5,
    S_TRAP  = 3'd6
  } state_t;

  // A zero TIMEOUT disables the watchdog; keep the counter one bit wide then.
  localparam int             WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT);

  state_t           state_r;
  state_t           next_s;
  logic [XLEN-1:0]  pc_r;
  logic [31:0]      instr_r;
  logic [CNT_W-1:0] instret_r;
  logic [1:0]       cause_r;
  logic [1:0]       cause_next_s;
  logic [WD_W-1:0]  wdog_r;
  logic [WD_W-1:0]  wd_inc_s;
  logic             wd_hit_s;
  logic             we_r;

  // Watchdog fires when this waiting cycle would bring the count to TIMEOUT.
  always_comb begin
    wd_inc_s = wdog_r + WD_W'(1);
    wd_hit_s = 1'b0;
    if (TIMEOUT != 0) begin
      wd_hit_s = (wd_inc_s == WD_LIM);
    end else begin
      wd_hit_s = 1'b0;
    end
  end

  // Next-state and trap-cause selection; prog overrides everything.
  always_comb begin
    next_s       = state_r;
    cause_next_s = cause_r;
    if (prog) begin
      next_s = S_PROG;
    end else begin
      case (state_r)
        S_PROG:  next_s = S_FETCH;
        S_FETCH: begin
          // An ack in the same cycle as the watchdog limit wins.
          if (mem.imem_ack)   next_s = S_EXEC;
          else if (wd_hit_s)  next_s = S_TRAP;
          else                next_s = S_FETCH;
        end
        S_EXEC: begin
          if (is_halt)                 next_s = S_HALT;
          else if (pc_next[1:0] != 2'b00) next_s = S_TRAP;
          else if (is_mem)             next_s = S_MEM;
          else                         next_s = S_WB;
        end
        S_MEM: begin
          if (mem.dmem_ack)   next_s = S_WB;
          else if (wd_hit_s)  next_s = S_TRAP;
          else                next_s = S_MEM;
        end
        S_WB:    next_s = S_FETCH;
        S_HALT:  next_s = S_HALT;
        S_TRAP:  next_s = S_TRAP;
        default: next_s = S_PROG;
      endcase
    end

    if (next_s == S_PROG) begin
      cause_next_s = 2'd0;
    end else if ((next_s == S_TRAP) && (state_r != S_TRAP)) begin
      case (state_r)
        S_FETCH: cause_next_s = 2'd2;
        S_MEM:   cause_next_s = 2'd3;
        default: cause_next_s = 2'd1;
      endcase
    end else begin
      cause_next_s = cause_r;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_PROG;
    end else begin
      state_r <= next_s;
    end
  end

  // pc, instruction latch, retire counter, trap cause, watchdog, store qualifier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r      <= RESET_PC;
      instr_r   <= 32'd0;
      instret_r <= {CNT_W{1'b0}};
      cause_r   <= 2'd0;
      wdog_r    <= {WD_W{1'b0}};
      we_r      <= 1'b0;
    end else begin
      cause_r <= cause_next_s;

      // Entering PROG already presents RESET_PC; otherwise only WB moves pc.
      if (next_s == S_PROG) begin
        pc_r <= RESET_PC;
      end else if (state_r == S_WB) begin
        pc_r <= pc_next;
      end

      if ((state_r == S_FETCH) && (next_s == S_EXEC)) begin
        instr_r <= mem.imem_rdata;
      end

      if (state_r == S_WB) begin
        instret_r <= instret_r + CNT_W'(1);
      end

      // Store qualifier is captured in EXEC so dmem_we never sees is_store live.
      if (state_r == S_EXEC) begin
        we_r <= is_store;
      end

      if (next_s != state_r) begin
        wdog_r <= {WD_W{1'b0}};
      end else if ((state_r == S_FETCH) || (state_r == S_MEM)) begin
        wdog_r <= wd_inc_s;
      end
    end
  end

  assign mem.imem_req  = (state_r == S_FETCH);
  assign mem.imem_addr = pc_r;
  assign mem.dmem_req  = (state_r == S_MEM);
  assign mem.dmem_we   = (state_r == S_MEM) && we_r;
  assign instr         = instr_r;
  assign pc            = pc_r;
  assign ex_stage      = (state_r == S_EXEC);
  assign wb_stage      = (state_r == S_WB);
  assign state         = state_r;
  assign instret       = instret_r;
  assign halted        = (state_r == S_HALT);
  assign trap          = (state_r == S_TRAP);
  assign trap_cause    = cause_r;

endmodule
